// File: rtl/corescore_stream_char_sink_if.sv
// Byte-stream handshake bundle between corescorecore and the character sink bridge.
//   tdata  : stream payload, DW bits
//   tlast  : marks the final byte of a frame
//   tvalid : producer has a byte on tdata/tlast
//   tready : consumer accepts; a transfer happens on tvalid & tready
// master = stream producer, slave = stream consumer.
interface corescore_stream_char_sink_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (
    output tdata,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/corescore_stream_char_sink.sv
// Buffered bridge from the corescorecore byte stream to a character sink with registered
// push semantics (JTAG-UART r_ena/r_val style). Incoming bytes are queued in a small FIFO.
// Whenever the sink signals ready, one character is taken (from the FIFO, or an inserted
// CR/LF after a frame's last byte) and presented on o_dat with a one-cycle o_val strobe.
//
// Ports:
//   i_clk       clock, all logic on the rising edge
//   i_rstn      synchronous active-low reset
//   s_axis      stream input (slave modport): tdata, tlast, tvalid in; tready out
//   i_sink_rdy  sink can accept a character in the following cycle
//   o_dat       character to the sink, registered; holds its value between pushes
//   o_val       push strobe, one character consumed per high cycle
//   o_level     FIFO occupancy, 0 .. 2**DEPTH_LOG2
//   o_frames    count of completed frames emitted, wraps at 16 bits
//
// Parameters:
//   DW          data width of stream and sink (>= 8); inserted EOL chars are zero-extended
//   DEPTH_LOG2  FIFO holds 2**DEPTH_LOG2 entries of {tlast, tdata}
//   EOL_MODE    0: no insertion, 1: LF after a tlast byte, 2: CR then LF after a tlast byte
module corescore_stream_char_sink #(
  parameter int unsigned DW         = 8,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned EOL_MODE   = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  corescore_stream_char_sink_if.slave s_axis,
  input  logic                        i_sink_rdy,
  output logic [DW-1:0]               o_dat,
  output logic                        o_val,
  output logic [DEPTH_LOG2:0]         o_level,
  output logic [15:0]                 o_frames
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  localparam logic [DW-1:0] CharCr = DW'(8'h0D);
  localparam logic [DW-1:0] CharLf = DW'(8'h0A);

  // Any mode other than 1 or 2 behaves as "no insertion": the tlast byte closes the frame.
  localparam bit EolNone = (EOL_MODE != 1) && (EOL_MODE != 2);
  localparam bit EolCrLf = (EOL_MODE == 2);

  typedef enum logic [1:0] {
    StData,
    StCr,
    StLf
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------------------------
  logic [DW:0]           mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  state_e                state_q, state_d;
  logic [DW-1:0]         dat_q, dat_d;
  logic                  val_q, val_d;
  logic [15:0]           frames_q, frames_d;

  // Combinational helpers
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          head_last;
  logic [DW-1:0] head_data;
  logic          have_char;
  logic [DW-1:0] char_sel;
  logic          emit;
  logic          pop;
  logic          frame_done;

  // ---------------------------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------------------------
  // Occupancy can reach exactly Depth, so its MSB alone flags full.
  assign full  = level_q[DEPTH_LOG2];
  assign empty = (level_q == '0);

  // Registered occupancy only: a pop in the same cycle does not open the input.
  // Held low during reset so nothing is taken while the bridge is being cleared.
  assign s_axis.tready = i_rstn & ~full;
  assign wr_en         = s_axis.tvalid & s_axis.tready;

  assign {head_last, head_data} = mem_q[rd_ptr_q];

  // Entry storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {s_axis.tlast, s_axis.tdata};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
    case ({wr_en, pop})
      2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Output FSM: state register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= StData;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output FSM: next state. States only advance when a character is actually emitted.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StData: begin
        if (pop && head_last && !EolNone) begin
          state_d = EolCrLf ? StCr : StLf;
        end
      end
      StCr: begin
        if (emit) begin
          state_d = StLf;
        end
      end
      StLf: begin
        if (emit) begin
          state_d = StData;
        end
      end
      default: state_d = StData;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Output FSM: character selection and emission
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    have_char  = 1'b0;
    char_sel   = '0;
    unique case (state_q)
      StData: begin
        have_char = ~empty;
        char_sel  = head_data;
      end
      StCr: begin
        have_char = 1'b1;
        char_sel  = CharCr;
      end
      StLf: begin
        have_char = 1'b1;
        char_sel  = CharLf;
      end
      default: begin
        have_char = 1'b0;
        char_sel  = '0;
      end
    endcase

    emit = i_sink_rdy & have_char;
    // EOL states synthesise their characters; only the data state drains the FIFO.
    pop  = emit & (state_q == StData);
    // A frame closes on its LF, or on the tlast byte itself when no EOL is inserted.
    frame_done = emit & ((state_q == StLf) | ((state_q == StData) & head_last & EolNone));
  end

  // ---------------------------------------------------------------------------------------------
  // Registered sink interface and status
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    val_d    = emit;
    dat_d    = emit ? char_sel : dat_q;
    frames_d = frames_q + {15'd0, frame_done};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dat_q    <= '0;
      val_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dat_q    <= dat_d;
      val_q    <= val_d;
      frames_q <= frames_d;
    end
  end

  assign o_dat    = dat_q;
  assign o_val    = val_q;
  assign o_level  = level_q;
  assign o_frames = frames_q;

endmodule

// File: tb/tb_corescore_stream_char_sink.sv
// Bench for corescore_stream_char_sink. Instance a uses EOL_MODE=2 (CR LF), instance b uses
// EOL_MODE=1 (LF). A per-instance reference queue holds the character sequence the sink must
// see, built directly from accepted bytes and the end-of-line rule.
module tb_corescore_stream_char_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a, rstn_b, rdy_a, rdy_b;
  logic [7:0]  dat_a, dat_b;
  logic        val_a, val_b;
  logic [4:0]  level_a, level_b;
  logic [15:0] frames_a, frames_b;

  corescore_stream_char_sink_if #(.DW(8)) ifa ();
  corescore_stream_char_sink_if #(.DW(8)) ifb ();

  corescore_stream_char_sink #(.DW(8), .DEPTH_LOG2(4), .EOL_MODE(2)) dut_a (
    .i_clk      (clk),
    .i_rstn     (rstn_a),
    .s_axis     (ifa),
    .i_sink_rdy (rdy_a),
    .o_dat      (dat_a),
    .o_val      (val_a),
    .o_level    (level_a),
    .o_frames   (frames_a)
  );

  corescore_stream_char_sink #(.DW(8), .DEPTH_LOG2(4), .EOL_MODE(1)) dut_b (
    .i_clk      (clk),
    .i_rstn     (rstn_b),
    .s_axis     (ifb),
    .i_sink_rdy (rdy_b),
    .o_dat      (dat_b),
    .o_val      (val_b),
    .o_level    (level_b),
    .o_frames   (frames_b)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------------------------
  // Reference model: expected character queue per instance, {frame_end, char}
  // ---------------------------------------------------------------------------------------------
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  int         fr[2];
  bit         prev_rdy[2];
  bit         mon_en = 1'b0;

  function automatic int qsz(input int d);
    return (d == 0) ? q_a.size() : q_b.size();
  endfunction

  task automatic qpush(input int d, input logic [8:0] e);
    if (d == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  // Instance a inserts CR LF, instance b inserts LF; the LF closes the frame.
  task automatic expect_byte(input int d, input logic [7:0] data, input logic last);
    qpush(d, {1'b0, data});
    if (last) begin
      if (d == 0) qpush(d, {1'b0, 8'h0D});
      qpush(d, {1'b1, 8'h0A});
    end
  endtask

  task automatic mon(input int d, input logic val, input logic [7:0] dat, input logic [15:0] frames,
                     input logic rstn, input logic tvalid, input logic tready,
                     input logic [7:0] tdata, input logic tlast, input logic rdy);
    logic [8:0] e;
    string      tag;
    tag = (d == 0) ? "a" : "b";
    if (val === 1'b1) begin
      check({tag, "_val_after_rdy"}, {31'd0, prev_rdy[d]}, 32'd1);
      if (qsz(d) == 0) begin
        checks++;
        $display("FAIL %s_extra_char: got %0h expected no character", tag, dat);
      end else begin
        e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
        check({tag, "_char"}, {24'd0, dat}, {24'd0, e[7:0]});
        if (e[8]) fr[d]++;
      end
    end
    check({tag, "_frames"}, {16'd0, frames}, fr[d] & 32'hFFFF);
    if (rstn !== 1'b1) begin
      if (d == 0) q_a.delete();
      else q_b.delete();
      fr[d]       = 0;
      prev_rdy[d] = 1'b0;
    end else begin
      if (tvalid && tready) expect_byte(d, tdata, tlast);
      prev_rdy[d] = rdy;
    end
  endtask

  // Inputs change #1 after posedge, so the negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, val_a, dat_a, frames_a, rstn_a, ifa.tvalid, ifa.tready, ifa.tdata, ifa.tlast, rdy_a);
      mon(1, val_b, dat_b, frames_b, rstn_b, ifb.tvalid, ifb.tready, ifb.tdata, ifb.tlast, rdy_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until every expected character has appeared, within a cycle budget.
  task automatic drain(input int d, input bit toggle, input int budget);
    int k;
    k = 0;
    while (qsz(d) != 0 && k < budget) begin
      if (d == 0) rdy_a = toggle ? ~rdy_a : 1'b1;
      else rdy_b = toggle ? ~rdy_b : 1'b1;
      tick();
      k++;
    end
    checks++;
    if (qsz(d) == 0) passed++;
    else $display("FAIL drain_%0d: got %0d chars outstanding expected 0", d, qsz(d));
    if (d == 0) check("a_drain_level", {27'd0, level_a}, 32'd0);
    else check("b_drain_level", {27'd0, level_b}, 32'd0);
  endtask

  typedef struct {
    logic        tvalid;
    logic [7:0]  tdata;
    logic        tlast;
    logic        rdy;
    logic        e_val;
    logic [7:0]  e_dat;
    logic        e_tready;
    logic [4:0]  e_level;
    logic [15:0] e_frames;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[15];
    int   n, cyc, sent, tl, vcount;

    // Instance a, EOL_MODE=2: one frame, then stalls around a second frame and its CR LF.
    vec[0]  = '{1'b1, 8'h41, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 5'd1, 16'd0};
    vec[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 5'd0, 16'd0};
    vec[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0D, 1'b1, 5'd0, 16'd0};
    vec[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0A, 1'b1, 5'd0, 16'd1};
    vec[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h0A, 1'b1, 5'd0, 16'd1};
    vec[5]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b1, 5'd1, 16'd1};
    vec[6]  = '{1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 8'h0A, 1'b1, 5'd2, 16'd1};
    vec[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h42, 1'b1, 5'd1, 16'd1};
    vec[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h42, 1'b1, 5'd1, 16'd1};
    vec[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h43, 1'b1, 5'd0, 16'd1};
    vec[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h43, 1'b1, 5'd0, 16'd1};
    vec[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0D, 1'b1, 5'd0, 16'd1};
    vec[12] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h0A, 1'b1, 5'd1, 16'd2};
    vec[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 5'd0, 16'd2};
    vec[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 5'd0, 16'd2};

    rstn_a = 1'b0; rstn_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    ifa.tvalid = 1'b1; ifa.tdata = 8'h5A; ifa.tlast = 1'b1;
    ifb.tvalid = 1'b0; ifb.tdata = 8'h00; ifb.tlast = 1'b0;

    // Reset held 4 cycles with a valid byte offered: nothing accepted or pushed.
    for (int i = 0; i < 4; i++) begin
      tick();
      mon_en = 1'b1;
      check("rst_tready", {31'd0, ifa.tready}, 32'd0);
      check("rst_val", {31'd0, val_a}, 32'd0);
      check("rst_level", {27'd0, level_a}, 32'd0);
    end
    ifa.tvalid = 1'b0;
    rstn_a = 1'b1;
    tick();
    check("post_rst_level", {27'd0, level_a}, 32'd0);
    check("post_rst_tready", {31'd0, ifa.tready}, 32'd1);
    check("post_rst_dat", {24'd0, dat_a}, 32'd0);

    // Table-driven cycle vectors.
    for (int i = 0; i < 15; i++) begin
      ifa.tvalid = vec[i].tvalid; ifa.tdata = vec[i].tdata; ifa.tlast = vec[i].tlast;
      rdy_a = vec[i].rdy;
      tick();
      check($sformatf("tbl%0d_val", i), {31'd0, val_a}, {31'd0, vec[i].e_val});
      check($sformatf("tbl%0d_dat", i), {24'd0, dat_a}, {24'd0, vec[i].e_dat});
      check($sformatf("tbl%0d_tready", i), {31'd0, ifa.tready}, {31'd0, vec[i].e_tready});
      check($sformatf("tbl%0d_level", i), {27'd0, level_a}, {27'd0, vec[i].e_level});
      check($sformatf("tbl%0d_frames", i), {16'd0, frames_a}, {16'd0, vec[i].e_frames});
    end
    ifa.tvalid = 1'b0;

    // Fill to full with the sink stalled, then release.
    rdy_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ifa.tvalid = 1'b1; ifa.tdata = 8'h10 + 8'(i); ifa.tlast = 1'b0;
      tick();
    end
    check("full_level", {27'd0, level_a}, 32'd16);
    check("full_tready", {31'd0, ifa.tready}, 32'd0);
    ifa.tdata = 8'hAA;
    rdy_a = 1'b1;
    tick();
    check("first_pop_level", {27'd0, level_a}, 32'd15);
    check("first_pop_tready", {31'd0, ifa.tready}, 32'd1);
    check("first_pop_dat", {24'd0, dat_a}, 32'h10);
    tick();
    ifa.tvalid = 1'b0;
    drain(0, 1'b0, 100);

    // Sink ready toggling every cycle while 32 random bytes stream in.
    n = 0; cyc = 0;
    while (n < 32 && cyc < 400) begin
      rdy_a = cyc[0];
      ifa.tvalid = 1'b1; ifa.tdata = 8'($urandom); ifa.tlast = ($urandom_range(0, 3) == 0);
      if (ifa.tready) n++;
      tick();
      cyc++;
    end
    ifa.tvalid = 1'b0;
    check("toggle_sent", n, 32'd32);
    drain(0, 1'b1, 400);
    rdy_a = 1'b1;

    // Reset while the CR of a frame is pending, with another byte still queued.
    rdy_a = 1'b0;
    ifa.tvalid = 1'b1; ifa.tdata = 8'h55; ifa.tlast = 1'b1;
    tick();
    ifa.tdata = 8'h66; ifa.tlast = 1'b0;
    tick();
    ifa.tvalid = 1'b0;
    rdy_a = 1'b1;
    tick();
    check("pre_cr_dat", {24'd0, dat_a}, 32'h55);
    check("pre_cr_level", {27'd0, level_a}, 32'd1);
    rstn_a = 1'b0;
    tick();
    check("cr_rst_val", {31'd0, val_a}, 32'd0);
    check("cr_rst_level", {27'd0, level_a}, 32'd0);
    check("cr_rst_frames", {16'd0, frames_a}, 32'd0);
    rstn_a = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (val_a === 1'b1) vcount++;
    end
    check("cr_rst_no_output", vcount, 32'd0);

    // Random traffic on instance b (LF mode) with random valid and sink ready.
    rstn_b = 1'b1;
    tick();
    sent = 0; tl = 0; cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      ifb.tvalid = ($urandom_range(0, 9) < 7);
      ifb.tdata  = 8'($urandom);
      ifb.tlast  = ($urandom_range(0, 7) == 0);
      rdy_b      = ($urandom_range(0, 9) < 6);
      if (ifb.tvalid && ifb.tready) begin
        sent++;
        if (ifb.tlast) tl++;
      end
      tick();
      cyc++;
    end
    ifb.tvalid = 1'b0;
    check("rand_sent", sent, 32'd1000);
    drain(1, 1'b0, 200);
    tick();
    check("rand_frames", {16'd0, frames_b}, tl & 32'hFFFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
